// File: rtl/shift_sequencer.sv
// Multi-cycle SRL/SLL controller: one 1-bit right shift per clock, SLL via bit reversal on entry/exit.
// Optional feature macro: SHIFT_SEQ_FLUSH_EN (adds the flush input).
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
`ifdef SHIFT_SEQ_FLUSH_EN
    input  logic               flush,
`endif
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dataOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     sreg;
    logic [SHAMT_W-1:0]   cnt;
    logic                 op_q;
    logic                 flush_req;

`ifdef SHIFT_SEQ_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // The single shifter stage: logical right shift by one when sel is set.
    function automatic logic [WIDTH-1:0] shifter_1bit(input logic [WIDTH-1:0] v, input logic sel);
        return sel ? {1'b0, v[WIDTH-1:1]} : v;
    endfunction

    // busy/done are registered alongside state so they change only at state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            op_q    <= 1'b0;
            dataOut <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (flush_req) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg  <= op ? rev(data) : data;
                        cnt   <= shamt;
                        op_q  <= op;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        sreg <= shifter_1bit(sreg, 1'b1);
                        cnt  <= cnt - 1'b1;
                    end else begin
                        dataOut <= op_q ? rev(sreg) : sreg;
                        state   <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table, hand-written corner sequences, random ops vs. arithmetic model.
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_out;

    shift_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .data    (data),
        .shamt   (shamt),
`ifdef SHIFT_SEQ_FLUSH_EN
        .flush   (flush),
`endif
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
        int          rej;
    } vec_t;

    function automatic logic [31:0] ref_shift(input logic o, input logic [31:0] d, input logic [4:0] s);
        return o ? (d << s) : (d >> s);
    endfunction

    task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    task automatic scramble_inputs();
        op    = 1'($urandom);
        data  = $urandom;
        shamt = 5'($urandom);
    endtask

    // Issues one op at cycle 0 and checks busy/done/dataOut every cycle up to two idle cycles after done.
    // rej > 0 asserts a start that must be ignored during that (busy) cycle.
    task automatic do_op(input logic o, input logic [31:0] d, input logic [4:0] s,
                         input logic [31:0] exp, input int rej, input string name);
        int last;
        last = int'(s) + 2;
        @(negedge clk);
        start = 1'b1; op = o; data = d; shamt = s;
        exp_q.push_back(exp);
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            check({name, ".busy"}, c, 32'(busy), (c <= last) ? 32'd1 : 32'd0);
            check({name, ".done"}, c, 32'(done), (c == last) ? 32'd1 : 32'd0);
            if (c == last && exp_q.size() > 0) cur_out = exp_q.pop_front();
            check({name, ".dataOut"}, c, dataOut, cur_out);
            start = (c == rej);
            scramble_inputs();
        end
        start = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; data = '0; shamt = '0; flush = 1'b0;
        cur_out = '0;

        vecs[0] = '{1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001, 0};
        vecs[1] = '{1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0};
        vecs[2] = '{1'b1, 32'h0000_0001, 5'd4,  32'h0000_0010, 0};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FF00, 0};
        vecs[4] = '{1'b0, 32'hF000_0000, 5'd4,  32'h0F00_0000, 3};
        vecs[5] = '{1'b1, 32'h8000_0001, 5'd31, 32'h8000_0000, 33};
        vecs[6] = '{1'b0, 32'h1234_5678, 5'd31, 32'h0000_0000, 0};

        repeat (2) @(negedge clk);
        check("reset.busy", 0, 32'(busy), 32'd0);
        check("reset.done", 0, 32'(done), 32'd0);
        check("reset.dataOut", 0, dataOut, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Busy-reject at cycle 3 (vec 4) and start coincident with done (vec 5) are folded into the table.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp, vecs[i].rej, $sformatf("vec%0d", i));
        end

        // Reset mid-operation: abandoned, cleared asynchronously, never completes.
        @(negedge clk);
        start = 1'b1; op = 1'b0; data = 32'hCAFE_F00D; shamt = 5'd20;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            scramble_inputs();
        end
        check("midrst.busy_before", 5, 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst.busy", 5, 32'(busy), 32'd0);
        check("midrst.done", 5, 32'(done), 32'd0);
        check("midrst.dataOut", 5, dataOut, 32'd0);
        cur_out = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 6; c < 30; c++) begin
            @(negedge clk);
            check("midrst.no_done", c, 32'(done), 32'd0);
            check("midrst.idle", c, 32'(busy), 32'd0);
        end
        do_op(1'b0, 32'hA5A5_0000, 5'd3, 32'h14B4_A000, 0, "after_rst");

`ifdef SHIFT_SEQ_FLUSH_EN
        do_op(1'b0, 32'h1234_5678, 5'd0, 32'h1234_5678, 0, "flush_prior");
        @(negedge clk);
        start = 1'b1; op = 1'b0; data = 32'hFFFF_0000; shamt = 5'd10;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (c == 4);
            if (c <= 4) check("flush.busy_pre", c, 32'(busy), 32'd1);
            else check("flush.busy_post", c, 32'(busy), 32'd0);
            check("flush.no_done", c, 32'(done), 32'd0);
            check("flush.dataOut", c, dataOut, 32'h1234_5678);
        end
        flush = 1'b0;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 1'b0; data = 32'h0000_00FF; shamt = 5'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("flush_idle.busy", c, 32'(busy), 32'd0);
            @(negedge clk);
        end
        do_op(1'b1, 32'h0000_00FF, 5'd2, 32'h0000_03FC, 0, "after_flush");
`endif

        // Random ops checked against the arithmetic model, with random ignored starts while busy.
        for (int n = 0; n < 40; n++) begin
            logic        r_op;
            logic [31:0] r_data;
            logic [4:0]  r_shamt;
            int          r_rej;
            r_op    = 1'($urandom);
            r_data  = $urandom;
            r_shamt = 5'($urandom_range(0, 31));
            r_rej   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, int'(r_shamt) + 2) : 0;
            do_op(r_op, r_data, r_shamt, ref_shift(r_op, r_data, r_shamt), r_rej, $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
